// File: rtl/binary_map_arbiter_pkg.sv
// Shared definitions for the binary-map SRAM arbiter: FSM encoding, idle SRAM
// command values, default geometry and the saturating wait-counter helper.
package binary_map_arbiter_pkg;

    localparam int DIMEN_DEF  = 1024;
    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GNT_RD = 2'd1,
        ST_GNT_WR = 2'd2,
        ST_TURN   = 2'd3
    } arb_state_e;

    localparam logic IDLE_CEN = 1'b1;
    localparam logic IDLE_WEN = 1'b1;
    localparam logic IDLE_REN = 1'b0;

    localparam logic [15:0] WAIT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == WAIT_MAX) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/binary_map_arbiter.sv
// Two-requester arbiter for the binary-map SRAM: token finder (reads) versus
// map builder (writes), burst-level grants with round robin on collisions.
module binary_map_arbiter
    import binary_map_arbiter_pkg::*;
#(
    parameter int DIMEN  = DIMEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EN,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic              rd_cen,
    input  logic              rd_wen,
    input  logic              rd_ren,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_cen,
    input  logic              wr_wen,
    input  logic              wr_ren,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_gnt,
    output logic              wr_gnt,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [15:0]       wait_cnt
);

    arb_state_e  state_q;
    logic        rd_gnt_q;
    logic        wr_gnt_q;
    logic        rr_wr_q;      // 1: map builder wins the next collision
    logic        ready_q;      // holds off arbitration for the first edge after reset
    logic        rd_valid_q;
    logic [15:0] wait_cnt_q;
    logic [15:0] wait_cnt_d;
    logic        rd_issue_s;
    logic        wait_inc_s;

    // Arbitration FSM with registered one-hot grants.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            rd_gnt_q <= 1'b0;
            wr_gnt_q <= 1'b0;
            rr_wr_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (EN && ready_q && (rd_req || wr_req)) begin
                        if (rd_req && (!wr_req || !rr_wr_q)) begin
                            state_q  <= ST_GNT_RD;
                            rd_gnt_q <= 1'b1;
                            wr_gnt_q <= 1'b0;
                            rr_wr_q  <= 1'b1;
                        end else begin
                            state_q  <= ST_GNT_WR;
                            rd_gnt_q <= 1'b0;
                            wr_gnt_q <= 1'b1;
                            rr_wr_q  <= 1'b0;
                        end
                    end else begin
                        state_q  <= ST_IDLE;
                        rd_gnt_q <= 1'b0;
                        wr_gnt_q <= 1'b0;
                    end
                end
                ST_GNT_RD: begin
                    if (!rd_req) begin
                        state_q  <= ST_TURN;
                        rd_gnt_q <= 1'b0;
                    end else begin
                        state_q  <= ST_GNT_RD;
                        rd_gnt_q <= 1'b1;
                    end
                    wr_gnt_q <= 1'b0;
                end
                ST_GNT_WR: begin
                    if (!wr_req) begin
                        state_q  <= ST_TURN;
                        wr_gnt_q <= 1'b0;
                    end else begin
                        state_q  <= ST_GNT_WR;
                        wr_gnt_q <= 1'b1;
                    end
                    rd_gnt_q <= 1'b0;
                end
                ST_TURN: begin
                    state_q  <= ST_IDLE;
                    rd_gnt_q <= 1'b0;
                    wr_gnt_q <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    rd_gnt_q <= 1'b0;
                    wr_gnt_q <= 1'b0;
                end
            endcase
        end
    end

    // SRAM command mux: owner passes straight through, otherwise idle command.
    always_comb begin
        mem_cen   = IDLE_CEN;
        mem_wen   = IDLE_WEN;
        mem_ren   = IDLE_REN;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (rd_gnt_q) begin
            mem_cen  = rd_cen;
            mem_wen  = rd_wen;
            mem_ren  = rd_ren;
            mem_addr = rd_addr;
        end else if (wr_gnt_q) begin
            mem_cen   = wr_cen;
            mem_wen   = wr_wen;
            mem_ren   = wr_ren;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end else begin
            mem_cen = IDLE_CEN;
        end
    end

    // Wait accounting only while the SRAM is owned or handing over.
    always_comb begin
        rd_issue_s = rd_gnt_q && !mem_cen && mem_ren;
        wait_inc_s = (state_q != ST_IDLE) &&
                     ((rd_req && !rd_gnt_q) || (wr_req && !wr_gnt_q));
        if (wait_inc_s) begin
            wait_cnt_d = sat_inc16(wait_cnt_q);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Read-valid strobe and wait counter.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_valid_q <= 1'b0;
            wait_cnt_q <= 16'd0;
        end else begin
            rd_valid_q <= rd_issue_s;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign rd_gnt   = rd_gnt_q;
    assign wr_gnt   = wr_gnt_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = mem_q;
    assign wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_binary_map_arbiter.sv
// Self-checking bench for binary_map_arbiter: scoreboard of expected read data
// plus directed scenario tasks for grants, muxing, enable, reset and saturation.
module tb_binary_map_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 16;
    localparam int BURST  = 1024 / 16;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              EN;
    logic              rd_req, wr_req;
    logic              rd_cen, rd_wen, rd_ren;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_cen, wr_wen, wr_ren;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_gnt, wr_gnt;
    logic              mem_cen, mem_wen, mem_ren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [15:0]       wait_cnt;

    int tests  = 0;
    int failed = 0;
    int valid_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    binary_map_arbiter #(.DIMEN(1024), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN),
        .rd_req(rd_req), .wr_req(wr_req),
        .rd_cen(rd_cen), .rd_wen(rd_wen), .rd_ren(rd_ren), .rd_addr(rd_addr),
        .wr_cen(wr_cen), .wr_wen(wr_wen), .wr_ren(wr_ren), .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_q(mem_q),
        .rd_data(rd_data), .rd_valid(rd_valid), .wait_cnt(wait_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] sram_word(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    // SRAM model: read data appears one cycle after the read command.
    always @(posedge CLK) begin
        if (!mem_cen && mem_ren) mem_q <= sram_word(mem_addr);
    end

    // Scoreboard: every rd_valid must match the oldest outstanding read.
    always @(negedge CLK) begin
        if (RESET && rd_valid) begin
            valid_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL rd_valid_unexpected: got rd_valid=1 data=%h, required no strobe", rd_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (rd_data !== exp_v) begin
                    failed++;
                    $display("FAIL rd_data: got %h, required %h", rd_data, exp_v);
                end
            end
        end
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        EN = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        rd_cen = 1'b1; rd_wen = 1'b1; rd_ren = 1'b0; rd_addr = '0;
        wr_cen = 1'b1; wr_wen = 1'b1; wr_ren = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        RESET = 1'b0;
        step(); step();
        RESET = 1'b1;
        step(); step();
        exp_q.delete();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            failed++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        RESET = 1'b0;
        #3;
        tests++; if (rd_gnt !== 1'b0 || wr_gnt !== 1'b0) begin failed++; $display("FAIL reset_gnt: got %b%b, required 00", rd_gnt, wr_gnt); end
        tests++; if (rd_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b, required 0", rd_valid); end
        tests++; if (wait_cnt !== 16'd0) begin failed++; $display("FAIL reset_wait: got %h, required 0", wait_cnt); end
        tests++; if ({mem_cen, mem_wen, mem_ren} !== 3'b110 || mem_addr !== 17'd0 || mem_wdata !== 16'd0) begin
            failed++; $display("FAIL reset_mem_idle: got cen/wen/ren=%b%b%b addr=%h wdata=%h, required 110/0/0", mem_cen, mem_wen, mem_ren, mem_addr, mem_wdata);
        end
        step();
        rd_req = 1'b1;
        RESET = 1'b1;
        step();
        tests++; if (rd_gnt !== 1'b0) begin failed++; $display("FAIL first_edge_gnt: got %b, required 0", rd_gnt); end
        step();
        tests++; if (rd_gnt !== 1'b1) begin failed++; $display("FAIL second_edge_gnt: got %b, required 1", rd_gnt); end
        rd_req = 1'b0;
        step(); step();
    endtask

    task automatic test_rd_burst;
        int v0;
        do_reset();
        rd_req = 1'b1;
        step();
        tests++; if (rd_gnt !== 1'b1 || wr_gnt !== 1'b0) begin failed++; $display("FAIL burst_grant: got %b%b, required 10", rd_gnt, wr_gnt); end
        v0 = valid_cnt;
        for (int i = 0; i < BURST; i++) begin
            rd_cen = 1'b0; rd_wen = 1'b1; rd_ren = 1'b1;
            rd_addr = 17'(5 + i * 1024);
            #1;
            tests++; if (mem_addr !== rd_addr || mem_cen !== 1'b0 || mem_ren !== 1'b1 || rd_gnt !== 1'b1) begin
                failed++; $display("FAIL burst_word%0d: got addr=%h cen=%b ren=%b gnt=%b, required addr=%h 0 1 1", i, mem_addr, mem_cen, mem_ren, rd_gnt, rd_addr);
            end
            exp_q.push_back(sram_word(rd_addr));
            step();
        end
        rd_cen = 1'b1; rd_ren = 1'b0; rd_req = 1'b0;
        step();
        tests++; if (rd_gnt !== 1'b0 || mem_cen !== 1'b1) begin failed++; $display("FAIL burst_turn: got gnt=%b cen=%b, required 0 1", rd_gnt, mem_cen); end
        step();
        tests++; if (valid_cnt - v0 !== BURST || exp_q.size() != 0) begin
            failed++; $display("FAIL burst_valid_count: got %0d pulses (%0d pending), required %0d", valid_cnt - v0, exp_q.size(), BURST);
        end
    endtask

    task automatic test_contention_and_write;
        do_reset();
        rd_req = 1'b1; wr_req = 1'b1;
        step();
        tests++; if (rd_gnt !== 1'b1 || wr_gnt !== 1'b0) begin failed++; $display("FAIL collide_first_rd: got %b%b, required 10", rd_gnt, wr_gnt); end
        for (int i = 0; i < 5; i++) begin
            if (i == 4) rd_req = 1'b0;
            step();
        end
        tests++; if (rd_gnt !== 1'b0 || wr_gnt !== 1'b0) begin failed++; $display("FAIL collide_turn: got %b%b, required 00", rd_gnt, wr_gnt); end
        step();
        tests++; if (wr_gnt !== 1'b0) begin failed++; $display("FAIL collide_idle: got wr_gnt=%b, required 0", wr_gnt); end
        step();
        tests++; if (wr_gnt !== 1'b1) begin failed++; $display("FAIL collide_wr_gnt: got %b, required 1", wr_gnt); end
        tests++; if (wait_cnt !== 16'd6) begin failed++; $display("FAIL collide_wait: got %0d, required 6", wait_cnt); end
        // rd requester competes with an active command while wr owns the SRAM
        rd_req = 1'b1; rd_cen = 1'b0; rd_ren = 1'b1; rd_addr = 17'd77;
        wr_cen = 1'b0; wr_wen = 1'b0; wr_ren = 1'b0; wr_addr = 17'd3; wr_data = 16'hA5A5;
        #1;
        tests++; if (mem_cen !== 1'b0 || mem_wen !== 1'b0 || mem_addr !== 17'd3 || mem_wdata !== 16'hA5A5) begin
            failed++; $display("FAIL write_path: got cen=%b wen=%b addr=%h wdata=%h, required 0 0 3 a5a5", mem_cen, mem_wen, mem_addr, mem_wdata);
        end
        step();
        wr_cen = 1'b1; wr_wen = 1'b1; wr_addr = 17'd9;
        #1;
        tests++; if (mem_addr !== 17'd9 || mem_cen !== 1'b1) begin failed++; $display("FAIL write_no_rd_leak: got addr=%h cen=%b, required 9 1", mem_addr, mem_cen); end
        rd_cen = 1'b1; rd_ren = 1'b0; wr_req = 1'b0;
        step();
        tests++; if (wr_gnt !== 1'b0 || rd_gnt !== 1'b0) begin failed++; $display("FAIL write_turn: got %b%b, required 00", rd_gnt, wr_gnt); end
        step(); step();
        tests++; if (rd_gnt !== 1'b1) begin failed++; $display("FAIL rd_after_wr: got %b, required 1", rd_gnt); end
        rd_req = 1'b0;
        step(); step();
    endtask

    task automatic test_enable;
        do_reset();
        EN = 1'b0; rd_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            tests++; if (rd_gnt !== 1'b0) begin failed++; $display("FAIL en_block%0d: got %b, required 0", i, rd_gnt); end
        end
        tests++; if (wait_cnt !== 16'd0) begin failed++; $display("FAIL en_wait: got %0d, required 0", wait_cnt); end
        EN = 1'b1;
        step();
        tests++; if (rd_gnt !== 1'b1) begin failed++; $display("FAIL en_grant: got %b, required 1", rd_gnt); end
        EN = 1'b0; wr_req = 1'b1;
        step(); step();
        wr_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (rd_gnt !== 1'b1) begin failed++; $display("FAIL en_hold%0d: got %b, required 1", i, rd_gnt); end
        end
        rd_req = 1'b0; EN = 1'b1;
        step(); step(); step();
        tests++; if (rd_gnt !== 1'b0 || wr_gnt !== 1'b0) begin failed++; $display("FAIL dropped_req: got %b%b, required 00", rd_gnt, wr_gnt); end
    endtask

    task automatic test_round_robin;
        do_reset();
        wr_req = 1'b1;
        step();
        tests++; if (wr_gnt !== 1'b1) begin failed++; $display("FAIL rr_wr_alone: got %b, required 1", wr_gnt); end
        wr_req = 1'b0;
        step();
        rd_req = 1'b1; wr_req = 1'b1;
        step(); step();
        tests++; if (rd_gnt !== 1'b1 || wr_gnt !== 1'b0) begin failed++; $display("FAIL rr_after_wr: got %b%b, required 10", rd_gnt, wr_gnt); end
        rd_req = 1'b0;
        step();
        rd_req = 1'b1;
        step(); step();
        tests++; if (rd_gnt !== 1'b0 || wr_gnt !== 1'b1) begin failed++; $display("FAIL rr_after_rd: got %b%b, required 01", rd_gnt, wr_gnt); end
        idle_inputs();
        step(); step();
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        rd_req = 1'b1; wr_req = 1'b1;
        step();
        for (int i = 0; i <= 20; i++) begin
            rd_cen = 1'b0; rd_wen = 1'b1; rd_ren = 1'b1;
            rd_addr = 17'(5 + i * 1024);
            exp_q.push_back(sram_word(rd_addr));
            if (i < 20) step();
        end
        #1;
        chk("midburst_wait_before", 32'(wait_cnt), 32'd20);
        RESET = 1'b0;
        #1;
        tests++; if (rd_gnt !== 1'b0 || rd_valid !== 1'b0 || wait_cnt !== 16'd0) begin
            failed++; $display("FAIL midburst_reset: got gnt=%b valid=%b wait=%0d, required 0 0 0", rd_gnt, rd_valid, wait_cnt);
        end
        tests++; if (mem_cen !== 1'b1 || mem_ren !== 1'b0 || mem_addr !== 17'd0) begin
            failed++; $display("FAIL midburst_mem_idle: got cen=%b ren=%b addr=%h, required 1 0 0", mem_cen, mem_ren, mem_addr);
        end
        exp_q.delete();
        idle_inputs();
        step();
        RESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++; if (rd_valid !== 1'b0) begin failed++; $display("FAIL midburst_stale_valid%0d: got %b, required 0", i, rd_valid); end
        end
    endtask

    task automatic test_saturate;
        do_reset();
        wr_req = 1'b1;
        step();
        chk("sat_wr_gnt", 32'(wr_gnt), 32'd1);
        rd_req = 1'b1;
        repeat (70000) @(posedge CLK);
        #1;
        chk("sat_wait_cnt", 32'(wait_cnt), 32'h0000FFFF);
        chk("sat_wr_held", 32'(wr_gnt), 32'd1);
        idle_inputs();
        step(); step();
    endtask

    initial begin
        mem_q = '0;
        idle_inputs();
        RESET = 1'b0;
        test_reset();
        test_rd_burst();
        test_contention_and_write();
        test_enable();
        test_round_robin();
        test_reset_mid_burst();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/binary_map_arbiter.md
BINARY_MAP_ARBITER -- requirements
Module: binary_map_arbiter

Interface
REQ-001 Parameter DIMEN, default 1024: token count; read burst length is DIMEN/16 words.
REQ-002 Parameter ADDR_W, default 17: binary-map SRAM address width.
REQ-003 Parameter DATA_W, default 16: binary-map SRAM word width.
REQ-004 CLK  input  1  clock; all state updates on the rising edge.
REQ-005 RESET  input  1  reset, asynchronous, active-low.
REQ-006 EN  input  1  arbitration enable; low blocks new grants, leaves a held grant untouched.
REQ-007 rd_req / wr_req  input  1 each  requester 0 (token finder, reads) / requester 1 (map builder, writes); held high for the whole burst.
REQ-008 rd_cen, rd_wen, rd_ren, rd_addr[ADDR_W-1:0]  input  requester 0 SRAM command (cen active-low, wen 1=read, ren active-high).
REQ-009 wr_cen, wr_wen, wr_ren, wr_addr[ADDR_W-1:0], wr_data[DATA_W-1:0]  input  requester 1 SRAM command.
REQ-010 rd_gnt / wr_gnt  output  1 each  grant, registered, one-hot or both zero.
REQ-011 mem_cen, mem_wen, mem_ren, mem_addr[ADDR_W-1:0], mem_wdata[DATA_W-1:0]  output  muxed SRAM command.
REQ-012 mem_q[DATA_W-1:0]  input  SRAM read data, valid one cycle after a read command.
REQ-013 rd_data[DATA_W-1:0] / rd_valid  output  read data to requester 0 and its valid strobe.
REQ-014 wait_cnt[15:0]  output  saturating count of cycles any request waited while the other requester held the grant.

Function
REQ-015 FSM states: IDLE, GNT_RD, GNT_WR, TURN.
REQ-016 IDLE: EN=1 with one request -> grant that requester next cycle; EN=0 -> remain IDLE.
REQ-017 IDLE: both requests same cycle -> grant the requester that did not hold the last grant (round robin); first grant after reset goes to rd.
REQ-018 GNT_x: grant held with no preemption while the owner's req=1, regardless of EN or the other request.
REQ-019 GNT_x: owner req falls -> TURN for exactly one cycle, then IDLE arbitration on the next cycle.
REQ-020 TURN and IDLE: mem_cen=1, mem_wen=1, mem_ren=0, mem_addr=0, mem_wdata=0.
REQ-021 GNT_x: mem_* = owner's command combinationally, same cycle; non-owner's command ignored.
REQ-022 Grant latency: request in IDLE -> grant asserted on the following edge; SRAM accesses are granted from that cycle.
REQ-023 rd_valid=1 one cycle after any cycle with rd_gnt=1, mem_cen=0, mem_ren=1; else 0; rd_data=mem_q unregistered.
REQ-024 A write by requester 1 (wr_cen=0, wr_wen=0) issued in a grant cycle reaches the SRAM that cycle; no write issued outside GNT_WR.
REQ-025 wait_cnt increments when a request is asserted, its requester is not granted, and the state is GNT_rd/GNT_wr/TURN; saturates at 16'hFFFF.
REQ-026 Request dropping while waiting: no grant issued, no side effect.
REQ-027 Burst of DIMEN/16 reads (64 at default) completes uninterrupted; arbiter places no limit on burst length.

Reset
REQ-028 RESET low: state IDLE, rd_gnt=0, wr_gnt=0, rd_valid=0, wait_cnt=0, round-robin pointer = rd; mem_* idle per REQ-020.
REQ-029 Reset mid-burst: grant drops immediately (asynchronous); in-flight read yields no rd_valid after release.
REQ-030 First grant possible on the second rising edge after RESET deasserts.

Structure
REQ-031 Shared package holds: FSM state encoding, idle SRAM command constants (cen=1, wen=1, ren=0), default DIMEN/ADDR_W/DATA_W.
REQ-032 Single module; no sub-module (mux and FSM are small); round-robin pointer is one flop.

Verification
REQ-033 rd_req alone, 64 reads at addr 5,1029,...,5+63*1024 -> rd_gnt next cycle, mem_addr tracks, rd_valid 64 pulses each one cycle after, TURN one cycle after req drop.
REQ-034 rd_req and wr_req same cycle after reset -> rd granted; after rd done -> TURN, then wr_gnt; wait_cnt = rd hold cycles + 1.
REQ-035 wr granted, write addr 3 data 16'hA5A5 -> mem_cen=0, mem_wen=0, mem_wdata=16'hA5A5 same cycle; rd_req high meanwhile -> mem_* never carries rd_addr.
REQ-036 EN=0 with rd_req high for 10 cycles -> no grant, wait_cnt=0; EN=1 -> rd_gnt next cycle; EN dropped mid-grant -> grant retained.
REQ-037 RESET asserted at burst word 20 -> rd_gnt, rd_valid, wait_cnt zero immediately; mem_* idle.
REQ-038 wr_req held continuously, rd_req waiting 70000 cycles -> wait_cnt saturates at 16'hFFFF.
